// File: rtl/niu_tx_arbiter.sv
// Packet-granular round-robin arbiter merging N_PORTS AXI-Stream requesters onto one
// TX stream, with the output driven from a 2-entry skid buffer.
module niu_tx_arbiter #(
   parameter int unsigned N_PORTS = 4,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned KEEP_W  = 8
) (
   input  logic                        clk156,
   input  logic                        aresetn,
   input  logic                        arb_en,
   input  logic [N_PORTS-1:0]          s_axis_tvalid,
   output logic [N_PORTS-1:0]          s_axis_tready,
   input  logic [N_PORTS*DATA_W-1:0]   s_axis_tdata,
   input  logic [N_PORTS*KEEP_W-1:0]   s_axis_tkeep,
   input  logic [N_PORTS-1:0]          s_axis_tlast,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic [DATA_W-1:0]           m_axis_tdata,
   output logic [KEEP_W-1:0]           m_axis_tkeep,
   output logic                        m_axis_tlast,
   output logic [N_PORTS-1:0]          grant,
   output logic [31:0]                 pkt_count
);

   localparam int unsigned IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   typedef enum logic {IDLE, XFER} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [KEEP_W-1:0] keep;
      logic              last;
   } beat_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   sel_q, sel_d;
   logic [N_PORTS-1:0] grant_q, grant_d;
   beat_t              head_q, head_d;
   beat_t              tail_q, tail_d;
   logic               head_v_q, head_v_d;
   logic               tail_v_q, tail_v_d;
   logic [31:0]        pkt_count_q, pkt_count_d;

   beat_t              in_beat;
   logic               in_valid;
   logic               push;
   logic               pop;
   logic               found;
   logic [IDX_W-1:0]   pick;
   int unsigned        cand;

   // Mux the granted port's beat.
   always_comb begin
      in_beat  = '0;
      in_valid = 1'b0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
         if (sel_q == IDX_W'(i)) begin
            in_beat.data = s_axis_tdata[i*DATA_W +: DATA_W];
            in_beat.keep = s_axis_tkeep[i*KEEP_W +: KEEP_W];
            in_beat.last = s_axis_tlast[i];
            in_valid     = s_axis_tvalid[i];
         end
      end
   end

   // Only the owner sees ready, and only while the skid has a free slot.
   always_comb begin
      s_axis_tready = '0;
      if (state_q == XFER && !tail_v_q) begin
         s_axis_tready = grant_q;
      end
   end

   assign push = (state_q == XFER) && in_valid && !tail_v_q;
   assign pop  = head_v_q && m_axis_tready;

   // Cyclic search for the first requester at or after rr_ptr.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = 0;
      for (int unsigned k = 0; k < N_PORTS; k++) begin
         cand = 32'(rr_ptr_q) + k;
         if (cand >= N_PORTS) begin
            cand = cand - N_PORTS;
         end
         if (!found && s_axis_tvalid[IDX_W'(cand)]) begin
            found = 1'b1;
            pick  = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      sel_d    = sel_q;
      grant_d  = grant_q;
      case (state_q)
         IDLE: begin
            if (arb_en && found) begin
               state_d = XFER;
               sel_d   = pick;
               grant_d = N_PORTS'(1) << pick;
            end
         end
         XFER: begin
            if (push && in_beat.last) begin
               state_d  = IDLE;
               grant_d  = '0;
               rr_ptr_d = (sel_q == IDX_W'(N_PORTS - 1)) ? '0 : sel_q + IDX_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Skid buffer: head drives the output, tail absorbs one beat of backpressure.
   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      head_v_d    = head_v_q;
      tail_v_d    = tail_v_q;
      pkt_count_d = pkt_count_q + 32'(pop && head_q.last);
      case ({push, pop})
         2'b10: begin
            if (!head_v_q) begin
               head_d   = in_beat;
               head_v_d = 1'b1;
            end else begin
               tail_d   = in_beat;
               tail_v_d = 1'b1;
            end
         end
         2'b01: begin
            if (tail_v_q) begin
               head_d = tail_q;
            end
            head_v_d = tail_v_q;
            tail_v_d = 1'b0;
         end
         2'b11: begin
            head_d   = in_beat;
            head_v_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk156 or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         sel_q       <= '0;
         grant_q     <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         head_v_q    <= 1'b0;
         tail_v_q    <= 1'b0;
         pkt_count_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         sel_q       <= sel_d;
         grant_q     <= grant_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         head_v_q    <= head_v_d;
         tail_v_q    <= tail_v_d;
         pkt_count_q <= pkt_count_d;
      end
   end

   assign m_axis_tvalid = head_v_q;
   assign m_axis_tdata  = head_q.data;
   assign m_axis_tkeep  = head_q.keep;
   assign m_axis_tlast  = head_q.last;
   assign grant         = grant_q;
   assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_niu_tx_arbiter.sv
// Scoreboard bench for niu_tx_arbiter: per-port packet drivers, expected beats queued
// in arbitration order, an output monitor that pops and compares.
module tb_niu_tx_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 64;
   localparam int unsigned KW = 8;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
   } beat_t;

   logic            clk156 = 1'b0;
   logic            aresetn = 1'b0;
   logic            arb_en = 1'b0;
   logic [N-1:0]    s_axis_tvalid = '0;
   logic [N-1:0]    s_axis_tready;
   logic [N*DW-1:0] s_axis_tdata = '0;
   logic [N*KW-1:0] s_axis_tkeep = '0;
   logic [N-1:0]    s_axis_tlast = '0;
   logic            m_axis_tvalid;
   logic            m_axis_tready = 1'b1;
   logic [DW-1:0]   m_axis_tdata;
   logic [KW-1:0]   m_axis_tkeep;
   logic            m_axis_tlast;
   logic [N-1:0]    grant;
   logic [31:0]     pkt_count;

   beat_t pq [N][$];
   beat_t exp_q [$];
   int    n_tests = 0;
   int    n_fail  = 0;

   niu_tx_arbiter #(.N_PORTS(N), .DATA_W(DW), .KEEP_W(KW)) dut (
      .clk156        (clk156),
      .aresetn       (aresetn),
      .arb_en        (arb_en),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .grant         (grant),
      .pkt_count     (pkt_count)
   );

   always #3 clk156 = ~clk156;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk156);
      #2;
   endtask

   // Queue a packet on a port driver and/or on the scoreboard.
   task automatic add_pkt(input int p, input int nb, input int tag, input logic [7:0] lk,
                          input bit to_port, input bit to_exp);
      beat_t b;
      for (int i = 0; i < nb; i++) begin
         b.d = (64'(tag) << 32) | 64'(i + 1);
         b.l = (i == nb - 1);
         b.k = b.l ? lk : 8'hFF;
         if (to_port) pq[p].push_back(b);
         if (to_exp) exp_q.push_back(b);
      end
   endtask

   task automatic flush_all();
      for (int p = 0; p < N; p++) pq[p].delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      flush_all();
      m_axis_tready = 1'b1;
      arb_en = 1'b1;
      tick(2);
      @(negedge clk156);
      aresetn = 1'b1;
      tick(1);
   endtask

   task automatic wait_grant(input logic [N-1:0] g, input string name);
      for (int i = 0; i < 50 && grant !== g; i++) tick(1);
      chk(name, 128'(grant), 128'(g));
   endtask

   task automatic wait_drain(input string name);
      int left;
      for (int i = 0; i < 300; i++) begin
         left = exp_q.size();
         for (int p = 0; p < N; p++) left += pq[p].size();
         if (left == 0) break;
         tick(1);
      end
      chk(name, 128'(exp_q.size()), 128'(0));
      tick(1);
   endtask

   // Port drivers: retire the beat handshaken at this edge, present the next one.
   initial begin
      logic [N-1:0] hs;
      forever begin
         @(negedge clk156);
         hs = s_axis_tvalid & s_axis_tready;
         @(posedge clk156);
         #1;
         for (int p = 0; p < N; p++) begin
            if (hs[p] && pq[p].size() > 0) void'(pq[p].pop_front());
            if (pq[p].size() > 0) begin
               s_axis_tvalid[p]         = 1'b1;
               s_axis_tdata[p*DW +: DW] = pq[p][0].d;
               s_axis_tkeep[p*KW +: KW] = pq[p][0].k;
               s_axis_tlast[p]          = pq[p][0].l;
            end else begin
               s_axis_tvalid[p]         = 1'b0;
               s_axis_tdata[p*DW +: DW] = '0;
               s_axis_tkeep[p*KW +: KW] = '0;
               s_axis_tlast[p]          = 1'b0;
            end
         end
      end
   end

   // Output monitor: scoreboard pop, stall stability, occupancy-based ready model.
   initial begin
      int    occ;
      bit    held_v;
      beat_t held;
      beat_t cur;
      beat_t e;
      occ = 0;
      held_v = 1'b0;
      held = '0;
      forever begin
         @(negedge clk156);
         if (!aresetn) begin
            occ = 0;
            held_v = 1'b0;
         end else begin
            cur = '{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast};
            chk("m_tvalid_vs_occupancy", 128'(m_axis_tvalid), 128'(occ != 0));
            chk("s_tready", 128'(s_axis_tready), 128'((grant != '0 && occ < 2) ? grant : '0));
            if (held_v) chk("stall_stable", {m_axis_tvalid, cur}, {1'b1, held});
            if (m_axis_tvalid && m_axis_tready) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_beat: got %0h, expected no beat", cur);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_beat", 128'(cur), 128'(e));
               end
            end
            held_v = m_axis_tvalid && !m_axis_tready;
            held = cur;
            occ = occ + int'((s_axis_tvalid & s_axis_tready) != '0)
                      - int'(m_axis_tvalid && m_axis_tready);
         end
      end
   end

   initial begin
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

      // Reset state
      tick(1);
      chk("rst_grant", 128'(grant), 128'(0));
      chk("rst_m_tvalid", 128'(m_axis_tvalid), 128'(0));
      chk("rst_m_tdata", 128'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 128'(0));
      chk("rst_s_tready", 128'(s_axis_tready), 128'(0));
      chk("rst_pkt_count", 128'(pkt_count), 128'(0));

      // Single 4-beat packet from port 2
      do_reset();
      add_pkt(2, 4, 0, 8'h0F, 1'b1, 1'b1);
      tick(1);
      chk("single_c0_grant", 128'(grant), 128'(0));
      tick(1);
      chk("single_c1_grant", 128'(grant), 128'(4'b0100));
      chk("single_c1_mvalid", 128'(m_axis_tvalid), 128'(0));
      tick(1);
      chk("single_c2_mvalid", 128'(m_axis_tvalid), 128'(1));
      chk("single_c2_mdata", 128'(m_axis_tdata), 128'(1));
      tick(3);
      chk("single_c5_grant", 128'(grant), 128'(0));
      chk("single_c5_mlast", 128'({m_axis_tvalid, m_axis_tlast, m_axis_tkeep}), 128'({2'b11, 8'h0F}));
      wait_drain("single_drain");
      chk("single_pkt_count", 128'(pkt_count), 128'(1));

      // Contention 0,1,3 then rr_ptr back at 0: port 0 wins over port 2
      do_reset();
      add_pkt(0, 3, 16'h10, 8'hFF, 1'b1, 1'b1);
      add_pkt(1, 3, 16'h11, 8'hFF, 1'b1, 1'b1);
      add_pkt(3, 3, 16'h13, 8'h3F, 1'b1, 1'b1);
      wait_drain("contend_drain");
      chk("contend_pkt_count", 128'(pkt_count), 128'(3));
      add_pkt(0, 1, 16'h20, 8'h01, 1'b1, 1'b1);
      add_pkt(2, 1, 16'h22, 8'h01, 1'b1, 1'b1);
      wait_drain("rrptr_drain");
      chk("rrptr_pkt_count", 128'(pkt_count), 128'(5));

      // Fairness: 40 single-beat packets, round-robin order
      do_reset();
      for (int r = 0; r < 10; r++)
         for (int p = 0; p < N; p++)
            add_pkt(p, 1, 16'h100 + r * 4 + p, 8'hFF, 1'b1, 1'b1);
      wait_drain("fair_drain");
      chk("fair_pkt_count", 128'(pkt_count), 128'(40));

      // Backpressure: 8 beats from port 1 with ready pattern 1,0,0,1
      do_reset();
      add_pkt(1, 8, 16'h30, 8'h07, 1'b1, 1'b1);
      for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
         m_axis_tready = pat[i % 4];
         tick(1);
      end
      m_axis_tready = 1'b1;
      wait_drain("bp_drain");
      chk("bp_pkt_count", 128'(pkt_count), 128'(1));

      // arb_en dropped mid-packet: port 0 finishes, port 1 waits
      do_reset();
      add_pkt(0, 5, 16'h40, 8'hFF, 1'b1, 1'b1);
      wait_grant(4'b0001, "arben_grant0");
      tick(1);
      add_pkt(1, 2, 16'h41, 8'h03, 1'b1, 1'b0);
      arb_en = 1'b0;
      tick(12);
      chk("arben_idle_grant", 128'(grant), 128'(0));
      chk("arben_port0_done", 128'(pkt_count), 128'(1));
      chk("arben_port0_beats", 128'(exp_q.size()), 128'(0));
      add_pkt(1, 2, 16'h41, 8'h03, 1'b0, 1'b1);
      arb_en = 1'b1;
      tick(1);
      chk("arben_grant1", 128'(grant), 128'(4'b0010));
      wait_drain("arben_drain");
      chk("arben_pkt_count", 128'(pkt_count), 128'(2));

      // Reset on beat 3 of 6, then a fresh packet from port 3
      do_reset();
      add_pkt(2, 6, 16'h50, 8'hFF, 1'b1, 1'b1);
      wait_grant(4'b0100, "mrst_grant2");
      tick(2);
      aresetn = 1'b0;
      flush_all();
      #1;
      chk("mrst_mvalid", 128'(m_axis_tvalid), 128'(0));
      chk("mrst_s_tready", 128'(s_axis_tready), 128'(0));
      chk("mrst_grant", 128'(grant), 128'(0));
      chk("mrst_pkt_count", 128'(pkt_count), 128'(0));
      tick(2);
      @(negedge clk156);
      aresetn = 1'b1;
      tick(1);
      add_pkt(3, 2, 16'h60, 8'h0F, 1'b1, 1'b1);
      wait_grant(4'b1000, "mrst_grant3");
      wait_drain("mrst_drain");
      chk("mrst_pkt_count_after", 128'(pkt_count), 128'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
